// File: rtl/if_stage_if.sv
// if_stage_pkg / if_stage_if: IF/ID bundle type and the fetch-stage bus.
// Ports (master = if_stage): imem request/response, redirect, id handshake.
package if_stage_pkg;
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] ia_plus_4;
    } id_params_t;
endpackage

interface if_stage_if;
    import if_stage_pkg::*;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_valid;
    logic        id_ready;
    id_params_t  id_params;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_params,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_target, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_params,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_target, id_ready
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch with credit-based imem requests and IF/ID queue.
// Ports: clk, rst (sync, active-high), bus (if_stage_if.master).
module if_stage #(
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
    parameter int          QUEUE_DEPTH     = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input logic        clk,
    input logic        rst,
    if_stage_if.master bus
);
    import if_stage_pkg::*;

    localparam int CW = $clog2(MAX_OUTSTANDING + QUEUE_DEPTH + 1);
    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam int RW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]   r_ia;
    logic [31:0]   r_req_ia [MAX_OUTSTANDING];
    logic [RW-1:0] r_rh;
    logic [RW-1:0] r_rt;
    logic [CW-1:0] r_live;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_qcnt;
    id_params_t    r_q [QUEUE_DEPTH];
    logic [QW-1:0] r_qh;
    logic [QW-1:0] r_qt;

    logic          w_credit;
    logic          w_fire;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_inflight;
    logic [CW-1:0] w_claimed;

    function automatic logic [RW-1:0] rinc(input logic [RW-1:0] p);
        return (p == RW'(MAX_OUTSTANDING - 1)) ? '0 : p + RW'(1);
    endfunction

    // Each live request holds a reserved queue slot, so pushes never overflow.
    assign w_inflight = r_live + r_drop;
    assign w_claimed  = r_live + r_qcnt;
    assign w_credit   = (w_inflight < CW'(MAX_OUTSTANDING)) &&
                        (w_claimed < CW'(QUEUE_DEPTH));

    assign bus.imem_req_valid = !rst && !bus.redirect_valid && w_credit;
    assign bus.imem_req_addr  = r_ia;
    assign w_fire = bus.imem_req_valid && bus.imem_req_ready;

    // Responses owed to pre-redirect requests are consumed by r_drop first.
    assign w_push = !rst && !bus.redirect_valid &&
                    bus.imem_rsp_valid && (r_drop == '0);
    assign w_pop  = (r_qcnt != '0) && bus.id_ready;

    assign bus.id_valid  = (r_qcnt != '0);
    assign bus.id_params = r_q[r_qh];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ia   <= RESET_ADDR;
            r_rh   <= '0;
            r_rt   <= '0;
            r_live <= '0;
            r_drop <= '0;
            r_qcnt <= '0;
            r_qh   <= '0;
            r_qt   <= '0;
        end else if (bus.redirect_valid) begin
            r_ia   <= bus.redirect_target & ~32'h3;
            r_rh   <= '0;
            r_rt   <= '0;
            r_qh   <= '0;
            r_qt   <= '0;
            r_qcnt <= '0;
            r_live <= '0;
            // Every outstanding request becomes stale; this cycle's
            // response (live or stale) is already retired.
            r_drop <= r_drop + r_live - CW'(bus.imem_rsp_valid);
        end else begin
            if (w_fire) begin
                r_ia <= r_ia + 32'd4;
                r_rt <= rinc(r_rt);
            end
            if (w_push) begin
                r_rh <= rinc(r_rh);
                r_qt <= r_qt + QW'(1);
            end
            if (bus.imem_rsp_valid && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
            if (w_pop) begin
                r_qh <= r_qh + QW'(1);
            end
            r_live <= r_live + CW'(w_fire) - CW'(w_push);
            r_qcnt <= r_qcnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_req_ia[r_rt] <= r_ia;
        end
        if (w_push) begin
            r_q[r_qt] <= '{ir: bus.imem_rsp_data,
                           ia_plus_4: r_req_ia[r_rh] + 32'd4};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.imem_rsp_valid && (w_inflight == '0)));
            assert (r_qcnt <= CW'(QUEUE_DEPTH));
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table on a RESET_ADDR=0 instance plus
// randomized traffic on a RESET_ADDR=0xFFFF_FFF8 instance vs. a stream model.
module tb_if_stage;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    if_stage_if ifa();
    if_stage_if ifb();

    if_stage u_a (.clk(clk), .rst(rst_a), .bus(ifa));

    if_stage #(.RESET_ADDR(32'hFFFF_FFF8)) u_b (
        .clk(clk), .rst(rst_b), .bus(ifb));

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rsp;
        logic [31:0] rd;
        logic        rdr;
        logic [31:0] tgt;
        logic        idr;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_iv;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t tv[$];

    function automatic logic [31:0] mw(input logic [31:0] a);
        return (a * 32'h0101_0101) ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(
        logic r, logic rdy, logic rsp, logic [31:0] rd,
        logic rdr, logic [31:0] tgt, logic idr,
        logic erv, logic [31:0] era, logic eiv, logic [31:0] epc4);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rsp = rsp; v.rd = rd;
        v.rdr = rdr; v.tgt = tgt; v.idr = idr;
        v.e_rv = erv; v.e_ra = era; v.e_iv = eiv; v.e_pc4 = epc4;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] first_req[$];
    logic [31:0] first_pc4[$];
    logic [31:0] exp_req;
    logic [31:0] exp_id;
    logic        rdv;
    logic        rspv;
    int          pops;

    initial begin
        {ifa.imem_req_ready, ifa.imem_rsp_valid, ifa.redirect_valid,
         ifa.id_ready} = '0;
        ifa.imem_rsp_data = '0;
        ifa.redirect_target = '0;
        {ifb.imem_req_ready, ifb.imem_rsp_valid, ifb.redirect_valid,
         ifb.id_ready} = '0;
        ifb.imem_rsp_data = '0;
        ifb.redirect_target = '0;

        // rst rdy rsp data rdr tgt idr | rv addr iv pc4
        tv.push_back(mk(0,1,0,0,0,0,1, 1,32'h0,0,0));
        tv.push_back(mk(0,1,1,mw(32'h0),0,0,1, 1,32'h4,0,0));
        tv.push_back(mk(0,1,1,mw(32'h4),0,0,1, 0,0,1,32'h4));
        tv.push_back(mk(0,1,0,0,0,0,1, 1,32'h8,1,32'h8));
        tv.push_back(mk(0,1,1,mw(32'h8),0,0,0, 1,32'hC,0,0));
        tv.push_back(mk(0,1,1,mw(32'hC),0,0,0, 0,0,1,32'hC));
        tv.push_back(mk(0,1,0,0,0,0,0, 0,0,1,32'hC));
        tv.push_back(mk(0,1,0,0,0,0,0, 0,0,1,32'hC));
        tv.push_back(mk(0,1,0,0,0,0,1, 0,0,1,32'hC));
        tv.push_back(mk(0,1,0,0,0,0,0, 1,32'h10,1,32'h10));
        tv.push_back(mk(0,1,0,0,0,0,1, 0,0,1,32'h10));
        tv.push_back(mk(0,1,0,0,0,0,1, 1,32'h14,0,0));
        tv.push_back(mk(0,1,0,0,1,32'h203,1, 0,0,0,0));
        tv.push_back(mk(0,1,1,mw(32'h10),0,0,1, 0,0,0,0));
        tv.push_back(mk(0,1,1,mw(32'h14),0,0,1, 1,32'h200,0,0));
        tv.push_back(mk(0,1,1,mw(32'h200),0,0,1, 1,32'h204,0,0));
        tv.push_back(mk(0,0,1,mw(32'h204),0,0,1, 0,0,1,32'h204));
        tv.push_back(mk(0,1,0,0,0,0,0, 1,32'h208,1,32'h208));
        tv.push_back(mk(0,1,1,mw(32'h208),1,32'h402,1, 0,0,1,32'h208));
        tv.push_back(mk(0,1,0,0,0,0,1, 1,32'h400,0,0));
        tv.push_back(mk(0,1,1,mw(32'h400),0,0,1, 1,32'h404,0,0));
        tv.push_back(mk(0,0,1,mw(32'h404),0,0,1, 0,0,1,32'h404));
        tv.push_back(mk(0,0,0,0,0,0,1, 1,32'h408,1,32'h408));
        tv.push_back(mk(0,0,0,0,0,0,1, 1,32'h408,0,0));
        tv.push_back(mk(0,1,0,0,0,0,1, 1,32'h408,0,0));
        tv.push_back(mk(0,1,1,mw(32'h408),0,0,0, 1,32'h40C,0,0));
        tv.push_back(mk(1,1,0,0,0,0,0, 0,0,1,32'h40C));
        tv.push_back(mk(0,1,0,0,0,0,1, 1,32'h0,0,0));
        tv.push_back(mk(0,0,1,mw(32'h0),0,0,1, 1,32'h4,0,0));
        tv.push_back(mk(0,0,0,0,0,0,1, 1,32'h4,1,32'h4));

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tv.size(); i++) begin
            rst_a = tv[i].rst;
            ifa.imem_req_ready = tv[i].rdy;
            ifa.imem_rsp_valid = tv[i].rsp;
            ifa.imem_rsp_data = tv[i].rd;
            ifa.redirect_valid = tv[i].rdr;
            ifa.redirect_target = tv[i].tgt;
            ifa.id_ready = tv[i].idr;
            #1;
            chk($sformatf("v%0d.req_valid", i),
                {31'b0, ifa.imem_req_valid}, {31'b0, tv[i].e_rv});
            if (tv[i].e_rv)
                chk($sformatf("v%0d.req_addr", i),
                    ifa.imem_req_addr, tv[i].e_ra);
            chk($sformatf("v%0d.id_valid", i),
                {31'b0, ifa.id_valid}, {31'b0, tv[i].e_iv});
            if (tv[i].e_iv) begin
                chk($sformatf("v%0d.pc4", i),
                    ifa.id_params.ia_plus_4, tv[i].e_pc4);
                chk($sformatf("v%0d.ir", i),
                    ifa.id_params.ir, mw(tv[i].e_pc4 - 32'd4));
            end
            @(posedge clk);
            #1;
        end
        {ifa.imem_req_ready, ifa.imem_rsp_valid, ifa.redirect_valid} = '0;

        // Random phase: every accepted request must be the next address of
        // the current stream, and every popped instruction the next word.
        rst_b = 1'b0;
        exp_req = 32'hFFFF_FFF8;
        exp_id = 32'hFFFF_FFF8;
        pops = 0;
        for (int c = 0; c < 3000; c++) begin
            ifb.imem_req_ready = ($urandom_range(3) != 0);
            ifb.id_ready = ($urandom_range(3) != 0);
            rdv = (pops >= 3) && (c > 40) && ($urandom_range(23) == 0);
            ifb.redirect_valid = rdv;
            ifb.redirect_target = ($urandom_range(3) == 0) ?
                (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            rspv = 1'b0;
            ifb.imem_rsp_data = '0;
            if (pend_addr.size() > 0 && pend_due[0] <= c &&
                $urandom_range(2) != 0) begin
                rspv = 1'b1;
                ifb.imem_rsp_data = mw(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            ifb.imem_rsp_valid = rspv;
            #1;
            if (ifb.imem_req_valid && ifb.imem_req_ready) begin
                chk("rnd.req_addr", ifb.imem_req_addr, exp_req);
                if (first_req.size() < 3) first_req.push_back(ifb.imem_req_addr);
                exp_req = exp_req + 32'd4;
                pend_addr.push_back(ifb.imem_req_addr);
                pend_due.push_back(c + 1 + int'($urandom_range(2)));
                chk("rnd.outstanding",
                    32'(pend_addr.size() + int'(rspv) <= 2), 32'd1);
            end
            if (ifb.id_valid && ifb.id_ready && !rdv) begin
                chk("rnd.ir", ifb.id_params.ir, mw(exp_id));
                chk("rnd.pc4", ifb.id_params.ia_plus_4, exp_id + 32'd4);
                if (first_pc4.size() < 3)
                    first_pc4.push_back(ifb.id_params.ia_plus_4);
                exp_id = exp_id + 32'd4;
                pops++;
            end
            if (rdv) begin
                exp_req = ifb.redirect_target & ~32'h3;
                exp_id = exp_req;
            end
            @(posedge clk);
            #1;
        end

        chk("wrap.nreq", 32'(first_req.size()), 32'd3);
        chk("wrap.npc4", 32'(first_pc4.size()), 32'd3);
        if (first_req.size() == 3 && first_pc4.size() == 3) begin
            chk("wrap.req0", first_req[0], 32'hFFFF_FFF8);
            chk("wrap.req1", first_req[1], 32'hFFFF_FFFC);
            chk("wrap.req2", first_req[2], 32'h0000_0000);
            chk("wrap.pc4_0", first_pc4[0], 32'hFFFF_FFFC);
            chk("wrap.pc4_1", first_pc4[1], 32'h0000_0000);
            chk("wrap.pc4_2", first_pc4[2], 32'h0000_0004);
        end
        chk("rnd.progress", 32'(pops > 300), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
